// File: rtl/regbank_sequencer.sv
// regbank_sequencer: write-port scheduler for the register bank.
// Arbitrates sp_init > irq > load > alu and turns each granted request into a
// registered enable/control/dest command. A load is split into a capture slot
// (control 3) and a commit slot (control 5) LOAD_LATENCY cycles later.
// Optional feature macro: REGBANK_SEQ_HAZARD_EN enables the load-use
// hazard_stall comparator; when undefined hazard_stall is tied to 0.
module regbank_sequencer #(
    parameter int LOAD_LATENCY    = 1,
    parameter int REG_INDEX_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       step,
    input  logic                       sp_init_req,
    output logic                       sp_init_ready,
    input  logic                       irq_req,
    output logic                       irq_ready,
    input  logic                       load_req,
    input  logic [REG_INDEX_WIDTH-1:0] load_dest,
    output logic                       load_ready,
    input  logic                       alu_req,
    input  logic [REG_INDEX_WIDTH-1:0] alu_dest,
    output logic                       alu_ready,
    input  logic [REG_INDEX_WIDTH-1:0] src_A,
    input  logic [REG_INDEX_WIDTH-1:0] src_B,
    output logic                       bank_enable,
    output logic [2:0]                 bank_control,
    output logic [REG_INDEX_WIDTH-1:0] bank_dest,
    output logic                       load_pending,
    output logic                       hazard_stall
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, LOAD_COMMIT} state_t;

    localparam logic [3:0] CNT_INIT        = 4'(LOAD_LATENCY - 1);
    localparam logic [2:0] CTL_NONE        = 3'd0;
    localparam logic [2:0] CTL_ALU         = 3'd1;
    localparam logic [2:0] CTL_SP_INIT     = 3'd2;
    localparam logic [2:0] CTL_LOAD_CAP    = 3'd3;
    localparam logic [2:0] CTL_IRQ         = 3'd4;
    localparam logic [2:0] CTL_LOAD_COMMIT = 3'd5;

    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [REG_INDEX_WIDTH-1:0]   pend_dest_q, pend_dest_d;
    logic                         enable_q, enable_d;
    logic [2:0]                   control_q, control_d;
    logic [REG_INDEX_WIDTH-1:0]   dest_q, dest_d;
    logic                         pending_q, pending_d;

    logic in_idle, in_wait;
    logic sp_xfer, irq_xfer, load_xfer, alu_xfer;

    // Handshake: each *_req is a single-cycle strobe; a transfer happens at a
    // posedge where req && ready. Readies are combinational from the current
    // state and higher-priority requests, so at most one transfer per cycle;
    // a requester that sees ready low must re-present its request.
    assign in_idle       = (state_q == IDLE);
    assign in_wait       = (state_q == LOAD_WAIT);
    assign sp_init_ready = in_idle;
    assign irq_ready     = in_idle && !sp_init_req;
    assign load_ready    = in_idle && !sp_init_req && !irq_req;
    assign alu_ready     = (in_idle && !sp_init_req && !irq_req && !load_req)
                         || (in_wait && (alu_dest != pend_dest_q));

    assign sp_xfer   = sp_init_req && sp_init_ready;
    assign irq_xfer  = irq_req && irq_ready;
    assign load_xfer = load_req && load_ready;
    assign alu_xfer  = alu_req && alu_ready;

    // Next-state and next bank command for the slot that starts at the next posedge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_dest_d = pend_dest_q;
        enable_d    = step;
        control_d   = CTL_NONE;
        dest_d      = '0;
        case (state_q)
            IDLE: begin
                if (sp_xfer) begin
                    enable_d  = 1'b1;
                    control_d = CTL_SP_INIT;
                end else if (irq_xfer) begin
                    enable_d  = 1'b1;
                    control_d = CTL_IRQ;
                end else if (load_xfer) begin
                    enable_d    = 1'b1;
                    control_d   = CTL_LOAD_CAP;
                    dest_d      = load_dest;
                    pend_dest_d = load_dest;
                    cnt_d       = CNT_INIT;
                    state_d     = (LOAD_LATENCY == 1) ? LOAD_COMMIT : LOAD_WAIT;
                end else if (alu_xfer) begin
                    enable_d  = 1'b1;
                    control_d = CTL_ALU;
                    dest_d    = alu_dest;
                end
            end
            LOAD_WAIT: begin
                if (alu_xfer) begin
                    enable_d  = 1'b1;
                    control_d = CTL_ALU;
                    dest_d    = alu_dest;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = LOAD_COMMIT;
                end
            end
            LOAD_COMMIT: begin
                enable_d  = 1'b1;
                control_d = CTL_LOAD_COMMIT;
                dest_d    = pend_dest_q;
                cnt_d     = 4'd0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Pending covers the capture slot through the commit slot inclusive.
        pending_d = (state_d != IDLE) || (state_q == LOAD_COMMIT);
    end

    // State and registered bank command; reset abandons any in-flight load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            pend_dest_q <= '0;
            enable_q    <= 1'b0;
            control_q   <= CTL_NONE;
            dest_q      <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_dest_q <= pend_dest_d;
            enable_q    <= enable_d;
            control_q   <= control_d;
            dest_q      <= dest_d;
            pending_q   <= pending_d;
        end
    end

    assign bank_enable  = enable_q;
    assign bank_control = control_q;
    assign bank_dest    = dest_q;
    assign load_pending = pending_q;

`ifdef REGBANK_SEQ_HAZARD_EN
    assign hazard_stall = pending_q && ((src_A == pend_dest_q) || (src_B == pend_dest_q));
`else
    logic unused_src;
    assign unused_src   = ^{src_A, src_B};
    assign hazard_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regbank_sequencer.sv
// Bench for regbank_sequencer: two instances (LOAD_LATENCY 1 and 3) share
// stimulus; a cycle-indexed transaction model predicts readies and slots.
module tb_regbank_sequencer;

  logic clock = 1'b0;
  logic reset;
  logic step, sp_init_req, irq_req, load_req, alu_req;
  logic [3:0] load_dest, alu_dest, src_A, src_B;

  logic [1:0] sp_rdy, irq_rdy, ld_rdy, alu_rdy, b_en, l_pend, h_stall;
  logic [1:0][2:0] b_ctrl;
  logic [1:0][3:0] b_dest;

  always #5 clock = ~clock;

  regbank_sequencer #(.LOAD_LATENCY(1), .REG_INDEX_WIDTH(4)) dut_l1 (
    .clock(clock), .reset(reset), .step(step),
    .sp_init_req(sp_init_req), .sp_init_ready(sp_rdy[0]),
    .irq_req(irq_req), .irq_ready(irq_rdy[0]),
    .load_req(load_req), .load_dest(load_dest), .load_ready(ld_rdy[0]),
    .alu_req(alu_req), .alu_dest(alu_dest), .alu_ready(alu_rdy[0]),
    .src_A(src_A), .src_B(src_B),
    .bank_enable(b_en[0]), .bank_control(b_ctrl[0]), .bank_dest(b_dest[0]),
    .load_pending(l_pend[0]), .hazard_stall(h_stall[0])
  );

  regbank_sequencer #(.LOAD_LATENCY(3), .REG_INDEX_WIDTH(4)) dut_l3 (
    .clock(clock), .reset(reset), .step(step),
    .sp_init_req(sp_init_req), .sp_init_ready(sp_rdy[1]),
    .irq_req(irq_req), .irq_ready(irq_rdy[1]),
    .load_req(load_req), .load_dest(load_dest), .load_ready(ld_rdy[1]),
    .alu_req(alu_req), .alu_dest(alu_dest), .alu_ready(alu_rdy[1]),
    .src_A(src_A), .src_B(src_B),
    .bank_enable(b_en[1]), .bank_control(b_ctrl[1]), .bank_dest(b_dest[1]),
    .load_pending(l_pend[1]), .hazard_stall(h_stall[1])
  );

  int checks = 0;
  int failures = 0;

  // Model: a load captured at slot cap commits at slot cap+lat.
  int lat[2] = '{1, 3};
  bit have[2];
  int cap[2];
  int cmt[2];
  logic [3:0] pd[2];
  int cyc = 0;

  logic [3:0] obs_rdy[2];
  logic obs_en[2];
  logic [2:0] obs_ctrl[2];
  logic [3:0] obs_dest[2];
  logic obs_pend[2];
  logic obs_haz[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ready(int m);
    if (have[m] && cyc == cmt[m]) return 4'b0000;
    if (have[m] && cyc > cap[m] && cyc < cmt[m]) return {3'b000, alu_dest != pd[m]};
    return {1'b1, !sp_init_req, !sp_init_req && !irq_req,
            !sp_init_req && !irq_req && !load_req};
  endfunction

  task automatic drive(input logic st, input logic sp, input logic iq, input logic ld,
                       input logic [3:0] ldd, input logic al, input logic [3:0] ald);
    step = st; sp_init_req = sp; irq_req = iq; load_req = ld;
    load_dest = ldd; alu_req = al; alu_dest = ald;
  endtask

  // One clock: check readies before the edge, then the slot after it.
  task automatic cycle();
    logic [3:0] r;
    logic e_en[2];
    logic [2:0] e_ctrl[2];
    logic [3:0] e_dest[2];
    logic e_pend, e_haz;
    #1;
    for (int m = 0; m < 2; m++) begin
      r = exp_ready(m);
      obs_rdy[m] = {sp_rdy[m], irq_rdy[m], ld_rdy[m], alu_rdy[m]};
      check($sformatf("L%0d_readies", lat[m]), 32'(obs_rdy[m]), 32'(r));
      e_en[m] = step; e_ctrl[m] = 3'd0; e_dest[m] = 4'd0;
      if (have[m] && cyc == cmt[m]) begin
        e_en[m] = 1'b1; e_ctrl[m] = 3'd5; e_dest[m] = pd[m];
      end else if (sp_init_req && r[3]) begin
        e_en[m] = 1'b1; e_ctrl[m] = 3'd2;
      end else if (irq_req && r[2]) begin
        e_en[m] = 1'b1; e_ctrl[m] = 3'd4;
      end else if (load_req && r[1]) begin
        e_en[m] = 1'b1; e_ctrl[m] = 3'd3; e_dest[m] = load_dest;
        have[m] = 1'b1; cap[m] = cyc; cmt[m] = cyc + lat[m]; pd[m] = load_dest;
      end else if (alu_req && r[0]) begin
        e_en[m] = 1'b1; e_ctrl[m] = 3'd1; e_dest[m] = alu_dest;
      end
    end
    @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      obs_en[m] = b_en[m]; obs_ctrl[m] = b_ctrl[m]; obs_dest[m] = b_dest[m];
      obs_pend[m] = l_pend[m]; obs_haz[m] = h_stall[m];
      e_pend = have[m] && cap[m] <= cyc && cyc <= cmt[m];
`ifdef REGBANK_SEQ_HAZARD_EN
      e_haz = e_pend && (src_A == pd[m] || src_B == pd[m]);
`else
      e_haz = 1'b0;
`endif
      check($sformatf("L%0d_enable", lat[m]), 32'(obs_en[m]), 32'(e_en[m]));
      check($sformatf("L%0d_control", lat[m]), 32'(obs_ctrl[m]), 32'(e_ctrl[m]));
      if (e_ctrl[m] == 3'd1 || e_ctrl[m] == 3'd3 || e_ctrl[m] == 3'd5)
        check($sformatf("L%0d_dest", lat[m]), 32'(obs_dest[m]), 32'(e_dest[m]));
      check($sformatf("L%0d_load_pending", lat[m]), 32'(obs_pend[m]), 32'(e_pend));
      check($sformatf("L%0d_hazard", lat[m]), 32'(obs_haz[m]), 32'(e_haz));
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_L%0d_outputs", tag, lat[m]),
            {20'd0, b_en[m], b_ctrl[m], b_dest[m], l_pend[m], h_stall[m]}, 32'd0);
    end
  endtask

  typedef struct {
    logic step, sp, irq, ld;
    logic [3:0] ld_dest;
    logic alu;
    logic [3:0] alu_dest;
    logic [3:0] rdy;
    logic en;
    logic [2:0] ctrl;
    logic [3:0] dest;
    logic pend;
  } vec_t;

  vec_t vt[10];
  logic [3:0] last_ld;

  initial begin
    // Expected behaviour of the LOAD_LATENCY=1 instance, slot by slot.
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 4'b1111, 1'b0, 3'd0, 4'd0,  1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 4'b1111, 1'b1, 3'd0, 4'd0,  1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 4'd2, 4'b1100, 1'b1, 3'd4, 4'd0,  1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 4'd2, 4'b1110, 1'b1, 3'd3, 4'd3,  1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2, 4'b0000, 1'b1, 3'd5, 4'd3,  1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2, 4'b1111, 1'b1, 3'd1, 4'd2,  1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 4'b1000, 1'b1, 3'd2, 4'd0,  1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0, 4'b1110, 1'b1, 3'd3, 4'd15, 1'b1};
    vt[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd4,  1'b0, 4'd0, 4'b0000, 1'b1, 3'd5, 4'd15, 1'b1};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 4'b1111, 1'b0, 3'd0, 4'd0,  1'b0};

    // Clock/reset
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    src_A = 4'd0; src_B = 4'd0;
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].step, vt[i].sp, vt[i].irq, vt[i].ld, vt[i].ld_dest, vt[i].alu, vt[i].alu_dest);
      cycle();
      check($sformatf("vec%0d_readies", i), 32'(obs_rdy[0]), 32'(vt[i].rdy));
      check($sformatf("vec%0d_enable", i), 32'(obs_en[0]), 32'(vt[i].en));
      check($sformatf("vec%0d_control", i), 32'(obs_ctrl[0]), 32'(vt[i].ctrl));
      if (vt[i].ctrl == 3'd1 || vt[i].ctrl == 3'd3 || vt[i].ctrl == 3'd5)
        check($sformatf("vec%0d_dest", i), 32'(obs_dest[0]), 32'(vt[i].dest));
      check($sformatf("vec%0d_pending", i), 32'(obs_pend[0]), 32'(vt[i].pend));
    end

    // LOAD_LATENCY=3: capture R5, ALU R2 in the wait slot, ALU R5 refused, commit R5
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0);
    cycle();
    check("l3_capture_ctrl", 32'(obs_ctrl[1]), 32'd3);
    check("l3_capture_dest", 32'(obs_dest[1]), 32'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2);
    cycle();
    check("l3_wait_alu_ready", 32'(obs_rdy[1][0]), 32'd1);
    check("l3_wait_alu_ctrl", 32'(obs_ctrl[1]), 32'd1);
    check("l3_wait_alu_dest", 32'(obs_dest[1]), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
    cycle();
    check("l3_same_dest_ready", 32'(obs_rdy[1][0]), 32'd0);
    check("l3_gap_ctrl", 32'(obs_ctrl[1]), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    cycle();
    check("l3_commit_ctrl", 32'(obs_ctrl[1]), 32'd5);
    check("l3_commit_dest", 32'(obs_dest[1]), 32'd5);
    check("l3_commit_pending", 32'(obs_pend[1]), 32'd1);
    cycle();
    check("l3_after_commit_pending", 32'(obs_pend[1]), 32'd0);

    // Hazard: load R7 with src_B = 7 held
    for (int i = 0; i < 2; i++) cycle();
    src_A = 4'd1; src_B = 4'd7;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) cycle();
    check("hazard_cleared", 32'(obs_haz[1]), 32'd0);
    src_A = 4'd0; src_B = 4'd0;

    // Reset asserted mid-cycle one cycle after a load was accepted
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    src_B = 4'd9;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    have[0] = 1'b0; have[1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("no_commit_after_reset_l1", 32'(obs_ctrl[0] == 3'd5), 32'd0);
      check("no_commit_after_reset_l3", 32'(obs_ctrl[1] == 3'd5), 32'd0);
    end

    // Randomized traffic against the model
    last_ld = 4'd0;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, 15)));
      if (load_req) last_ld = load_dest;
      src_A = 4'($urandom_range(0, 15));
      src_B = ($urandom_range(0, 1) == 1) ? last_ld : 4'($urandom_range(0, 15));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
